// File: rtl/control_in_capture_fifo_pkg.sv
// Shared types for the control_in capture buffer: record layout, capture modes
// and a width helper used wherever the packed record is sized.
package control_in_capture_pkg;

    localparam int INSTR_W_DEF = 16;

    typedef enum logic [1:0] {
        CAP_ALL      = 2'd0,
        CAP_CHANGE   = 2'd1,
        CAP_COMPLETE = 2'd2
    } cap_mode_e;

    // Field order matches the packed out_rec bus, MSB first.
    typedef struct packed {
        logic                   complete_data;
        logic                   complete_instr;
        logic [INSTR_W_DEF-1:0] IR;
        logic [INSTR_W_DEF-1:0] IR_Exec;
        logic [2:0]             psr;
        logic [2:0]             NZP;
        logic [INSTR_W_DEF-1:0] Instr_dout;
    } ctrl_rec_t;

    function automatic int rec_width(input int instr_w);
        return 3 * instr_w + 8;
    endfunction

endpackage

// File: rtl/control_in_capture_fifo_if.sv
// Bundle input, capture controls and drain port of the capture buffer.
// The slave modport is the buffer itself; master is the surrounding logic.
interface control_in_capture_fifo_if #(
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 8,
    parameter int TS_W    = 16,
    parameter int DROP_W  = 8
);
    localparam int REC_W = control_in_capture_pkg::rec_width(INSTR_W);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               enable;
    logic [1:0]         mode;
    logic               clear_ovf;
    logic               complete_data;
    logic               complete_instr;
    logic [INSTR_W-1:0] IR;
    logic [INSTR_W-1:0] IR_Exec;
    logic [2:0]         psr;
    logic [2:0]         NZP;
    logic [INSTR_W-1:0] Instr_dout;
    logic               out_valid;
    logic               out_ready;
    logic [REC_W-1:0]   out_rec;
    logic [TS_W-1:0]    out_ts;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [DROP_W-1:0]  drop_count;

    modport master (
        output enable, mode, clear_ovf,
        output complete_data, complete_instr, IR, IR_Exec, psr, NZP, Instr_dout,
        output out_ready,
        input  out_valid, out_rec, out_ts, count, overflow, drop_count
    );

    modport slave (
        input  enable, mode, clear_ovf,
        input  complete_data, complete_instr, IR, IR_Exec, psr, NZP, Instr_dout,
        input  out_ready,
        output out_valid, out_rec, out_ts, count, overflow, drop_count
    );

endinterface

// File: rtl/control_in_capture_fifo_sync_fifo.sv
// Generic show-ahead synchronous FIFO: the head entry is visible on dout while
// count is non-zero; dout reads as zero when empty.
module ctrl_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, wr_en, rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/control_in_capture_fifo.sv
// Capture buffer for the LC3 control_in bundle: filters samples by mode,
// timestamps them, queues them and keeps sticky overflow/drop accounting.
module control_in_capture_fifo
    import control_in_capture_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 8,
    parameter int TS_W    = 16,
    parameter int DROP_W  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    control_in_capture_fifo_if.slave bus
);

    localparam int REC_W = rec_width(INSTR_W);
    localparam int ENT_W = REC_W + TS_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [REC_W-1:0]  bundle;
    logic [REC_W-1:0]  prev_q, prev_d;
    logic              first_q, first_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              req, full, empty, push, pop, drop;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  fifo_dout;

    assign bundle = {bus.complete_data, bus.complete_instr, bus.IR, bus.IR_Exec,
                     bus.psr, bus.NZP, bus.Instr_dout};

    // Reserved mode 3 falls through to the completion filter.
    always_comb begin
        req = 1'b0;
        if (bus.enable) begin
            case (bus.mode)
                CAP_ALL:    req = 1'b1;
                CAP_CHANGE: req = first_q || (bundle != prev_q);
                default:    req = bus.complete_data || bus.complete_instr;
            endcase
        end
    end

    assign full  = (fifo_count == CNT_W'(DEPTH));
    assign empty = (fifo_count == '0);
    assign pop   = !empty && bus.out_ready;
    assign push  = req && (!full || pop);
    assign drop  = req && full && !pop;

    always_comb begin
        ts_d       = ts_q + TS_W'(1);
        prev_d     = bundle;
        first_d    = !bus.enable;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (bus.clear_ovf) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        // Applied after the clear so a same-cycle drop still gets counted.
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_d != '1) drop_d = drop_d + DROP_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q       <= '0;
            prev_q     <= '0;
            first_q    <= 1'b1;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            first_q    <= first_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    ctrl_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({bundle, ts_q}),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign bus.out_valid  = !empty;
    assign bus.out_rec    = fifo_dout[ENT_W-1:TS_W];
    assign bus.out_ts     = fifo_dout[TS_W-1:0];
    assign bus.count      = fifo_count;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;

endmodule

// File: doc/control_in_capture_fifo.md
Name: control_in_capture_fifo

Overview:
- Parametrised capture buffer for the LC3 control_in signal bundle: complete_data, complete_instr, IR, IR_Exec, psr, NZP, Instr_dout.
- Samples the bundle under a selectable capture mode and timestamps each sample.
- Stores samples in a DEPTH-entry FIFO and drains them over a valid/ready port.
- Sits between the control_in bus and trace/scoreboard logic. It generalises the fixed 16-bit bundle in width and adds buffering, filtering and overflow accounting.

Parameters:
- INSTR_W, 16, width of IR, IR_Exec, Instr_dout.
- DEPTH, 8, FIFO entries. Power of two, at least 2.
- TS_W, 16, timestamp counter width.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  capture enable
- mode  in  2  capture mode: 0 = every cycle, 1 = on change, 2 = on complete, 3 = reserved (behaves as 2)
- clear_ovf  in  1  clears overflow and drop_count
- complete_data  in  1  bundle field
- complete_instr  in  1  bundle field
- IR  in  INSTR_W  bundle field
- IR_Exec  in  INSTR_W  bundle field
- psr  in  3  bundle field
- NZP  in  3  bundle field
- Instr_dout  in  INSTR_W  bundle field
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head entry
- out_rec  out  3*INSTR_W+8  packed record {complete_data, complete_instr, IR, IR_Exec, psr, NZP, Instr_dout}
- out_ts  out  TS_W  timestamp of the head entry
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky flag: a capture was dropped
- drop_count  out  DROP_W  number of dropped captures, saturating

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO pointers, count, timestamp, prev-sample register, overflow and drop_count go to 0.
  - out_valid = 0; out_rec and out_ts = 0.
  - first_flag = 1.
  - Reset mid-operation flushes all entries. There is no partial drain.
- Timestamp: free-running, increments every cycle, wraps from 2^TS_W-1 to 0. A sample taken at an edge carries the timestamp value before that edge.
- Capture request, evaluated each cycle with enable = 1:
  - mode 0: always.
  - mode 1: the bundle differs from the prev-sample register, or first_flag = 1.
  - mode 2/3: complete_data or complete_instr is high.
  - enable = 0 means no request.
- prev-sample register loads the bundle every cycle regardless of capture or drop.
- first_flag is set on reset and whenever enable = 0. It clears after any cycle in which enable = 1.
- Push: request and (not full, or pop in the same cycle). Simultaneous push and pop when full is accepted, so count stays at DEPTH.
- Pop: out_valid and out_ready.
- Simultaneous push and pop when empty: the push is stored; out_valid rises the next cycle (no bypass).
- Drop: request while full with no pop.
  - overflow is set (sticky).
  - drop_count increments, saturating at 2^DROP_W-1.
  - FIFO contents are unchanged.
- clear_ovf clears overflow and drop_count. If a drop occurs in the same cycle, the drop wins: overflow = 1, drop_count = 1.
- Latency: a sample captured at edge N drives out_valid = 1 and out_rec/out_ts from edge N onward, if the FIFO was empty. Show-ahead head; out_rec is stable while out_valid and not out_ready.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from count.
- A mode change takes effect in the same cycle. It does not flush the FIFO.

Decomposition:
- Shared package control_in_capture_pkg contains:
  - ctrl_rec_t: packed struct of the seven fields, parametrised via INSTR_W localparam defaults.
  - cap_mode_e enum: CAP_ALL, CAP_CHANGE, CAP_COMPLETE.
  - Helper function rec_width.
- Natural sub-module: ctrl_sync_fifo, a generic show-ahead synchronous FIFO with parameters WIDTH and DEPTH and ports push, pop, din, dout, count. The top handles capture filtering, the timestamp and drop accounting.

Test Plan:
- Reset then mode 0, enable = 1 for 3 cycles with IR = 16'h1234, out_ready = 0 -> count = 3, out_rec.IR = 16'h1234, out_ts = 0, 1, 2 on successive pops.
- Mode 1, hold the bundle constant 5 cycles, then change NZP 3'b010 -> 3'b100 -> exactly 2 entries: the first-cycle capture and the change; second entry NZP = 3'b100.
- Mode 2, pulse complete_instr on cycles 4 and 9 with IR_Exec = 16'hA5A5 / 16'h5A5A -> 2 entries, timestamps differ by 5.
- DEPTH = 8, mode 0, out_ready = 0 for 12 cycles -> count = 8, overflow = 1, drop_count = 4. Then clear_ovf -> 0/0; entries intact.
- Full FIFO with out_ready = 1 and a capture in the same cycle -> count remains 8, drop_count unchanged, the popped entry is the oldest.
- Assert reset mid-stream with count = 5 -> out_valid = 0 and count = 0 immediately (asynchronous). After release, the first mode-1 cycle captures unconditionally.
